// File: rtl/ysyx_24100006_axi_sram_slave_if.sv
// AXI4 channel bundle between the arbiter's sram_axi_* side and the SRAM slave.
// The slave modport is the memory; the master modport is whatever drives it.
interface ysyx_24100006_axi_sram_slave_if;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [1:0]  axi_rresp;
  logic [31:0] axi_rdata;
  logic        axi_rlast;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_rready,
    input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
    output axi_arready, axi_rvalid, axi_rresp, axi_rdata, axi_rlast,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp
  );

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_rready,
    output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
    input  axi_arready, axi_rvalid, axi_rresp, axi_rdata, axi_rlast,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp
  );
endinterface

// File: rtl/ysyx_24100006_axi_sram_slave.sv
// AXI4 word-array memory slave with INCR bursts, byte strobes and programmable
// read/write response latency; read and write channels run independent FSMs.
module ysyx_24100006_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 1
) (
  input logic                           clk,
  input logic                           reset,
  ysyx_24100006_axi_sram_slave_if.slave axi
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [7:0]  RD_LAT_C  = 8'(RD_LAT);
  localparam logic [7:0]  WR_LAT_C  = 8'(WR_LAT);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3} w_state_e;

  // DECERR outranks SLVERR, which outranks OKAY.
  function automatic logic [1:0] bresp_enc(input logic dec, input logic slv);
    logic [1:0] resp;
    if (dec) begin
      resp = 2'b11;
    end else if (slv) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
    end
    return resp;
  endfunction

  logic [31:0] mem_r [DEPTH_WORDS];

  // Read channel state
  r_state_e    r_state_r, r_state_nxt_s;
  logic [31:0] r_addr_r, r_addr_nxt_s;
  logic [7:0]  r_len_r, r_len_nxt_s;
  logic [2:0]  r_size_r, r_size_nxt_s;
  logic [7:0]  r_beat_r, r_beat_nxt_s;
  logic [7:0]  r_wait_r, r_wait_nxt_s;
  logic        r_load_s;
  logic [31:0] r_off_s;
  logic        r_hit_s;
  logic [IDX_W-1:0] r_idx_s;
  logic        arready_r, rvalid_r, rlast_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;

  // Write channel state
  w_state_e    w_state_r, w_state_nxt_s;
  logic [31:0] w_addr_r, w_addr_nxt_s;
  logic [7:0]  w_len_r, w_len_nxt_s;
  logic [2:0]  w_size_r, w_size_nxt_s;
  logic [7:0]  w_beat_r, w_beat_nxt_s;
  logic [7:0]  w_wait_r, w_wait_nxt_s;
  logic        w_dec_r, w_dec_nxt_s;
  logic        w_slv_r, w_slv_nxt_s;
  logic        w_fire_s;
  logic [31:0] w_off_s;
  logic        w_hit_s;
  logic [IDX_W-1:0] w_idx_s;
  logic        mem_we_s;
  logic        awready_r, wready_r, bvalid_r;
  logic [1:0]  bresp_r;

  // Read next-state; the beat to load is always described by the *_nxt_s values.
  always_comb begin
    r_state_nxt_s = r_state_r;
    r_addr_nxt_s  = r_addr_r;
    r_len_nxt_s   = r_len_r;
    r_size_nxt_s  = r_size_r;
    r_beat_nxt_s  = r_beat_r;
    r_wait_nxt_s  = r_wait_r;
    r_load_s      = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (axi.axi_arvalid && arready_r) begin
          r_addr_nxt_s = axi.axi_araddr;
          r_len_nxt_s  = axi.axi_arlen;
          r_size_nxt_s = axi.axi_arsize;
          r_beat_nxt_s = 8'd0;
          if (RD_LAT == 0) begin
            r_state_nxt_s = R_DATA;
            r_load_s      = 1'b1;
          end else begin
            r_state_nxt_s = R_WAIT;
            r_wait_nxt_s  = RD_LAT_C;
          end
        end else begin
          r_state_nxt_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_wait_r <= 8'd1) begin
          r_state_nxt_s = R_DATA;
          r_wait_nxt_s  = 8'd0;
          r_load_s      = 1'b1;
        end else begin
          r_wait_nxt_s  = r_wait_r - 8'd1;
        end
      end
      R_DATA: begin
        if (rvalid_r && axi.axi_rready) begin
          if (rlast_r) begin
            r_state_nxt_s = R_IDLE;
          end else begin
            r_addr_nxt_s = r_addr_r + (32'd1 << r_size_r);
            r_beat_nxt_s = r_beat_r + 8'd1;
            r_load_s     = 1'b1;
          end
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Per-beat decode of the beat about to be loaded.
  always_comb begin
    r_off_s = r_addr_nxt_s - BASE_ADDR;
    r_hit_s = (r_off_s < MEM_BYTES);
    r_idx_s = r_off_s[IDX_W+1:2];
  end

  // Read state and registered R-channel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_r <= R_IDLE;
      r_addr_r  <= 32'd0;
      r_len_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_beat_r  <= 8'd0;
      r_wait_r  <= 8'd0;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= 2'b00;
    end else begin
      r_state_r <= r_state_nxt_s;
      r_addr_r  <= r_addr_nxt_s;
      r_len_r   <= r_len_nxt_s;
      r_size_r  <= r_size_nxt_s;
      r_beat_r  <= r_beat_nxt_s;
      r_wait_r  <= r_wait_nxt_s;
      arready_r <= (r_state_nxt_s == R_IDLE);
      rvalid_r  <= (r_state_nxt_s == R_DATA);
      if (r_load_s) begin
        rlast_r <= (r_beat_nxt_s == r_len_nxt_s);
        if (r_hit_s) begin
          rdata_r <= mem_r[r_idx_s];
          rresp_r <= 2'b00;
        end else begin
          rdata_r <= 32'd0;
          rresp_r <= 2'b11;
        end
      end
    end
  end

  // Write beat decode at the current beat address.
  always_comb begin
    w_fire_s = (w_state_r == W_DATA) && wready_r && axi.axi_wvalid;
    w_off_s  = w_addr_r - BASE_ADDR;
    w_hit_s  = (w_off_s < MEM_BYTES);
    w_idx_s  = w_off_s[IDX_W+1:2];
    mem_we_s = w_fire_s && w_hit_s;
  end

  // Write next-state; error flags accumulate over the burst.
  always_comb begin
    w_state_nxt_s = w_state_r;
    w_addr_nxt_s  = w_addr_r;
    w_len_nxt_s   = w_len_r;
    w_size_nxt_s  = w_size_r;
    w_beat_nxt_s  = w_beat_r;
    w_wait_nxt_s  = w_wait_r;
    w_dec_nxt_s   = w_dec_r;
    w_slv_nxt_s   = w_slv_r;
    case (w_state_r)
      W_IDLE: begin
        if (axi.axi_awvalid && awready_r) begin
          w_addr_nxt_s  = axi.axi_awaddr;
          w_len_nxt_s   = axi.axi_awlen;
          w_size_nxt_s  = axi.axi_awsize;
          w_beat_nxt_s  = 8'd0;
          w_dec_nxt_s   = 1'b0;
          w_slv_nxt_s   = 1'b0;
          w_state_nxt_s = W_DATA;
        end else begin
          w_state_nxt_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_fire_s) begin
          w_dec_nxt_s  = w_dec_r | ~w_hit_s;
          // wlast must coincide exactly with beat awlen; early or missing is SLVERR
          w_slv_nxt_s  = w_slv_r | (axi.axi_wlast != (w_beat_r == w_len_r));
          w_addr_nxt_s = w_addr_r + (32'd1 << w_size_r);
          w_beat_nxt_s = w_beat_r + 8'd1;
          if (axi.axi_wlast) begin
            if (WR_LAT == 0) begin
              w_state_nxt_s = W_RESP;
            end else begin
              w_state_nxt_s = W_WAIT;
              w_wait_nxt_s  = WR_LAT_C;
            end
          end else begin
            w_state_nxt_s = W_DATA;
          end
        end else begin
          w_state_nxt_s = W_DATA;
        end
      end
      W_WAIT: begin
        if (w_wait_r <= 8'd1) begin
          w_state_nxt_s = W_RESP;
          w_wait_nxt_s  = 8'd0;
        end else begin
          w_wait_nxt_s  = w_wait_r - 8'd1;
        end
      end
      W_RESP: begin
        if (bvalid_r && axi.axi_bready) begin
          w_state_nxt_s = W_IDLE;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write state and registered AW/W/B-channel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_r <= W_IDLE;
      w_addr_r  <= 32'd0;
      w_len_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_beat_r  <= 8'd0;
      w_wait_r  <= 8'd0;
      w_dec_r   <= 1'b0;
      w_slv_r   <= 1'b0;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      w_state_r <= w_state_nxt_s;
      w_addr_r  <= w_addr_nxt_s;
      w_len_r   <= w_len_nxt_s;
      w_size_r  <= w_size_nxt_s;
      w_beat_r  <= w_beat_nxt_s;
      w_wait_r  <= w_wait_nxt_s;
      w_dec_r   <= w_dec_nxt_s;
      w_slv_r   <= w_slv_nxt_s;
      awready_r <= (w_state_nxt_s == W_IDLE);
      wready_r  <= (w_state_nxt_s == W_DATA);
      bvalid_r  <= (w_state_nxt_s == W_RESP);
      bresp_r   <= (w_state_nxt_s == W_RESP) ? bresp_enc(w_dec_nxt_s, w_slv_nxt_s) : 2'b00;
    end
  end

  // Byte-lane array write; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.axi_wstrb[b]) begin
          mem_r[w_idx_s][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
        end
      end
    end
  end

  assign axi.axi_arready = arready_r;
  assign axi.axi_rvalid  = rvalid_r;
  assign axi.axi_rdata   = rdata_r;
  assign axi.axi_rresp   = rresp_r;
  assign axi.axi_rlast   = rlast_r;
  assign axi.axi_awready = awready_r;
  assign axi.axi_wready  = wready_r;
  assign axi.axi_bvalid  = bvalid_r;
  assign axi.axi_bresp   = bresp_r;

endmodule

// File: tb/tb_ysyx_24100006_axi_sram_slave.sv
// Scoreboard bench for the AXI SRAM slave: a word model predicts every R beat
// and B response at issue time; the DUT's outputs are popped and compared.
module tb_ysyx_24100006_axi_sram_slave;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;
  localparam int          LIMIT  = 64;
  localparam logic [31:0] TOP    = BASE + 32'(4 * DEPTH) - 32'd4;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  rd_exp_t rd_q[$];
  logic [1:0] b_q[$];
  logic [31:0] model[int];

  always #5 clk = ~clk;

  ysyx_24100006_axi_sram_slave_if axi();

  ysyx_24100006_axi_sram_slave #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .axi(axi)
  );

  function automatic bit in_rng(input logic [31:0] a);
    longint la, lb;
    la = longint'({32'd0, a});
    lb = longint'({32'd0, BASE});
    return (la >= lb) && (la < lb + 64'(4 * DEPTH));
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] data0, input logic [3:0] strb, input int last_at);
    int cnt, lat, k;
    bit hs, dec;
    logic [31:0] a, d, w;
    logic [1:0] exp_b;
    dec = 1'b0;
    axi.axi_awaddr = addr; axi.axi_awlen = len; axi.axi_awsize = 3'd2; axi.axi_awvalid = 1'b1;
    hs = 1'b0; cnt = 0;
    while (!hs && cnt < LIMIT) begin
      @(negedge clk); hs = axi.axi_awready;
      @(posedge clk); #1; cnt++;
    end
    axi.axi_awvalid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL aw_timeout addr=%h got awready=0 exp handshake", addr);
      return;
    end
    for (int b = 0; b <= last_at; b++) begin
      a = addr + 32'(b * 4);
      d = data0 + 32'(b) * 32'h0101_0101;
      axi.axi_wvalid = 1'b1; axi.axi_wdata = d; axi.axi_wstrb = strb; axi.axi_wlast = (b == last_at);
      hs = 1'b0; cnt = 0;
      while (!hs && cnt < LIMIT) begin
        @(negedge clk); hs = axi.axi_wready;
        @(posedge clk); #1; cnt++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL w_timeout beat=%0d got wready=0 exp handshake", b);
      end
      if (in_rng(a)) begin
        k = int'((a - BASE) >> 2);
        w = model.exists(k) ? model[k] : 32'h0;
        for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = d[8*i +: 8];
        model[k] = w;
      end else begin
        dec = 1'b1;
      end
    end
    axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0;
    exp_b = dec ? 2'b11 : ((last_at != int'(len)) ? 2'b10 : 2'b00);
    b_q.push_back(exp_b);
    axi.axi_bready = 1'b1;
    hs = 1'b0; lat = 0;
    while (!hs && lat < LIMIT) begin
      @(negedge clk);
      if (axi.axi_bvalid) hs = 1'b1; else lat++;
    end
    exp_b = b_q.pop_front();
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL b_timeout addr=%h got bvalid=0 exp 1", addr);
    end else begin
      if (axi.axi_bresp !== exp_b) begin
        errors++;
        $display("FAIL bresp addr=%h got %b exp %b", addr, axi.axi_bresp, exp_b);
      end
      checks++;
      if (lat != WR_LAT) begin
        errors++;
        $display("FAIL b_latency addr=%h got %0d exp %0d", addr, lat, WR_LAT);
      end
    end
    @(posedge clk); #1;
    axi.axi_bready = 1'b0;
  endtask

  task automatic axi_read_req(input logic [31:0] addr, input logic [7:0] len);
    int cnt, k;
    bit hs;
    logic [31:0] a;
    rd_exp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 32'(b * 4);
      if (in_rng(a)) begin
        k = int'((a - BASE) >> 2);
        e.data = model.exists(k) ? model[k] : 32'h0;
        e.resp = 2'b00;
      end else begin
        e.data = 32'h0;
        e.resp = 2'b11;
      end
      e.last = (b == int'(len));
      rd_q.push_back(e);
    end
    axi.axi_araddr = addr; axi.axi_arlen = len; axi.axi_arsize = 3'd2; axi.axi_arvalid = 1'b1;
    hs = 1'b0; cnt = 0;
    while (!hs && cnt < LIMIT) begin
      @(negedge clk); hs = axi.axi_arready;
      @(posedge clk); #1; cnt++;
    end
    axi.axi_arvalid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr=%h got arready=0 exp handshake", addr);
    end
  endtask

  task automatic collect_reads(input int n, input bit toggle);
    int got, cyc;
    bit rr;
    rd_exp_t e;
    got = 0; cyc = 0; rr = 1'b1;
    while (got < n && cyc < LIMIT * 4) begin
      axi.axi_rready = rr;
      @(negedge clk);
      if (!toggle && got > 0) begin
        checks++;
        if (axi.axi_rvalid !== 1'b1) begin
          errors++;
          $display("FAIL r_bubble after beat %0d got rvalid=%b exp 1", got, axi.axi_rvalid);
        end
      end
      if (axi.axi_rvalid && rd_q.size() > 0) begin
        e = rd_q[0];
        checks++;
        if (axi.axi_rdata !== e.data || axi.axi_rresp !== e.resp || axi.axi_rlast !== e.last) begin
          errors++;
          $display("FAIL rbeat%0d got data=%h resp=%b last=%b exp data=%h resp=%b last=%b",
                   got, axi.axi_rdata, axi.axi_rresp, axi.axi_rlast, e.data, e.resp, e.last);
        end
        if (rr) begin
          e = rd_q.pop_front();
          got++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) rr = ~rr;
    end
    axi.axi_rready = 1'b0;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL r_timeout got %0d beats exp %0d", got, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({axi.axi_arready, axi.axi_awready, axi.axi_wready, axi.axi_rvalid, axi.axi_rlast, axi.axi_bvalid} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl got ar/aw/w/rv/rl/bv=%b exp 110000",
               {axi.axi_arready, axi.axi_awready, axi.axi_wready, axi.axi_rvalid, axi.axi_rlast, axi.axi_bvalid});
    end
    checks++;
    if (axi.axi_rdata !== 32'h0 || axi.axi_rresp !== 2'b00 || axi.axi_bresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b exp 0", axi.axi_rdata, axi.axi_rresp, axi.axi_bresp);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_preload();
    axi_write(BASE, 8'd15, 32'h1122_3340, 4'b1111, 15);
    axi_write(TOP, 8'd0, 32'h5A5A_0F0F, 4'b1111, 0);
  endtask

  task automatic test_single_read();
    int lat;
    rd_exp_t e;
    axi_read_req(BASE, 8'd0);
    axi.axi_rready = 1'b1;
    lat = 0;
    while (!axi.axi_rvalid && lat < LIMIT) begin
      @(negedge clk);
      if (!axi.axi_rvalid) lat++;
    end
    e = rd_q.pop_front();
    checks++;
    if (lat != RD_LAT) begin
      errors++;
      $display("FAIL r_latency got %0d exp %0d", lat, RD_LAT);
    end
    checks++;
    if (axi.axi_rdata !== e.data || axi.axi_rresp !== e.resp || axi.axi_rlast !== e.last) begin
      errors++;
      $display("FAIL single_read got data=%h resp=%b last=%b exp data=%h resp=%b last=%b",
               axi.axi_rdata, axi.axi_rresp, axi.axi_rlast, e.data, e.resp, e.last);
    end
    @(posedge clk); #1;
    axi.axi_rready = 1'b0;
  endtask

  task automatic test_burst_stall();
    axi_read_req(BASE + 32'h10, 8'd3);
    collect_reads(4, 1'b1);
  endtask

  task automatic test_strobe_write();
    axi_write(BASE + 32'h4, 8'd0, 32'hAABB_CCDD, 4'b0110, 0);
    axi_read_req(BASE + 32'h4, 8'd0);
    collect_reads(1, 1'b0);
  endtask

  task automatic test_resp_errors();
    axi_write(BASE + 32'h20, 8'd1, 32'hC0DE_0000, 4'b1111, 0);
    axi_write(BASE + 32'h40, 8'd0, 32'h7700_1100, 4'b1111, 1);
    axi_read_req(BASE + 32'h40, 8'd1);
    collect_reads(2, 1'b0);
    axi_read_req(32'h7FFF_FFFC, 8'd0);
    collect_reads(1, 1'b0);
  endtask

  task automatic test_top_cross();
    axi_read_req(TOP, 8'd1);
    collect_reads(2, 1'b0);
    axi_write(TOP, 8'd1, 32'h1357_9BDF, 4'b1111, 1);
    axi_write(TOP, 8'd0, 32'h2468_ACE0, 4'b1111, 1);
    axi_read_req(TOP, 8'd0);
    collect_reads(1, 1'b0);
  endtask

  task automatic test_wstrb_zero();
    axi_write(BASE + 32'h8, 8'd0, 32'hDEAD_BEEF, 4'b0000, 0);
    axi_read_req(BASE + 32'h8, 8'd0);
    collect_reads(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    axi_write(BASE + 32'h30, 8'd3, 32'h0F1E_2D3C, 4'b1111, 3);
    axi_read_req(BASE + 32'h24, 8'd7);
    collect_reads(8, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int cyc, seen;
    rd_exp_t e;
    axi_read_req(BASE, 8'd3);
    axi.axi_rready = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 1 && cyc < LIMIT) begin
      @(negedge clk);
      if (axi.axi_rvalid) begin
        e = rd_q.pop_front();
        seen++;
        checks++;
        if (axi.axi_rdata !== e.data) begin
          errors++;
          $display("FAIL mid_beat0 got %h exp %h", axi.axi_rdata, e.data);
        end
      end
      @(posedge clk); #1; cyc++;
    end
    @(negedge clk);
    checks++;
    if (axi.axi_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat1_valid got %b exp 1", axi.axi_rvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (axi.axi_rvalid !== 1'b0 || axi.axi_rlast !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rvalid=%b rlast=%b exp 0 0", axi.axi_rvalid, axi.axi_rlast);
    end
    rd_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    axi.axi_rready = 1'b0;
    @(negedge clk);
    checks++;
    if (axi.axi_arready !== 1'b1 || axi.axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got arready=%b rvalid=%b exp 1 0", axi.axi_arready, axi.axi_rvalid);
    end
    @(posedge clk); #1;
    axi_read_req(BASE + 32'h4, 8'd1);
    collect_reads(2, 1'b0);
  endtask

  initial begin
    axi.axi_arvalid = 1'b0; axi.axi_araddr = 32'h0; axi.axi_arlen = 8'h0; axi.axi_arsize = 3'd2;
    axi.axi_rready  = 1'b0;
    axi.axi_awvalid = 1'b0; axi.axi_awaddr = 32'h0; axi.axi_awlen = 8'h0; axi.axi_awsize = 3'd2;
    axi.axi_wvalid  = 1'b0; axi.axi_wdata = 32'h0; axi.axi_wstrb = 4'h0; axi.axi_wlast = 1'b0;
    axi.axi_bready  = 1'b0;
    test_reset();
    test_preload();
    test_single_read();
    test_burst_stall();
    test_strobe_write();
    test_resp_errors();
    test_top_cross();
    test_wstrb_zero();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
